fetch_stage: RTL and testbench

Instruction-fetch stage of the in-order RV32I pipeline; sits directly upstream of decode and drives its instr_in / pc_in_dec inputs from registered outputs.
- Owns the program counter and issues word requests to instruction memory over a req/ack handshake.
- Honours the decode back-pressure stall.
- Takes pipeline redirects from the branch/jump resolution logic.

---
 rtl/fetch_stage.sv | 163 ++++++++++++++++
 tb/tb_fetch_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage for the in-order RV32I pipeline.
// Owns the PC, issues word requests to instruction memory over a req/ack
// handshake, honours decode back-pressure and takes branch/jump redirects.
// instr_out / pc_out / valid_out are registered and feed decode directly.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        req,            // pipeline clock
  input  logic        reset,          // synchronous, active-low
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  // IDLE : single dead cycle after reset release
  // FETCH: request outstanding at pc_q
  // HOLD : fetched word parked while decode stalls, no request
  // DROP : waiting out a request that a redirect made stale
  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;

  logic [31:0] target;
  logic [31:0] pc_inc;

  // Redirect targets are word aligned; the low bits are ignored.
  assign target = {redirect_pc_in[31:2], 2'b00};
  logic  unused_target_lsbs;
  assign unused_target_lsbs = ^redirect_pc_in[1:0];

  // Wraps modulo 2^32 without any flag.
  assign pc_inc = pc_q + 32'd4;

  // Memory sees a request while fetching and while draining a stale request.
  assign imem_req_out  = (state_q == S_FETCH) || (state_q == S_DROP);
  assign imem_addr_out = (state_q == S_DROP) ? drop_addr_q : pc_q;

  assign instr_out = instr_q;
  assign pc_out    = pc_out_q;
  assign valid_out = valid_q;

  // Next-state and output-register logic; redirect > ack > stall.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (redirect_in) begin
          pc_d    = target;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (!imem_ack_in) begin
            // The request in flight cannot be withdrawn; remember its
            // address so it stays stable until memory accepts it.
            drop_addr_d = pc_q;
            state_d     = S_DROP;
          end
        end else if (imem_ack_in) begin
          pc_d = pc_inc;
          if (stall_in) begin
            hold_instr_d = imem_rdata_in;
            hold_pc_d    = pc_q;
            state_d      = S_HOLD;
          end else begin
            instr_d  = imem_rdata_in;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
          end
        end else if (!stall_in) begin
          // Memory wait with decode ready: hand decode a bubble.
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end

      S_HOLD: begin
        if (redirect_in) begin
          pc_d    = target;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = S_FETCH;
        end else if (!stall_in) begin
          instr_d  = hold_instr_q;
          pc_out_d = hold_pc_q;
          valid_d  = 1'b1;
          state_d  = S_FETCH;
        end
      end

      S_DROP: begin
        if (redirect_in) begin
          pc_d = target;
        end
        if (imem_ack_in) begin
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge req) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (!reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      drop_addr_q  <= 32'h0;
      hold_instr_q <= 32'h0;
      hold_pc_q    <= 32'h0;
      instr_q      <= NOP_INSTR;
      pc_out_q     <= 32'h0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run, checked
// against an architectural model of the fetch stage kept in this file.
// Two instances run side by side: default reset PC and one near the wrap.
module tb_fetch_stage;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        req = 1'b0;
  always #5 req = ~req;

  logic        reset;
  logic        stall_in;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;

  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic        imem_req0, imem_req1;
  logic [31:0] imem_addr0, imem_addr1;
  logic [31:0] instr0, instr1;
  logic [31:0] pc0, pc1;
  logic        valid0, valid1;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .req(req), .reset(reset), .stall_in(stall_in), .redirect_in(redirect_in),
    .redirect_pc_in(redirect_pc_in), .imem_req_out(imem_req0),
    .imem_addr_out(imem_addr0), .imem_ack_in(ack0), .imem_rdata_in(rdata0),
    .instr_out(instr0), .pc_out(pc0), .valid_out(valid0)
  );

  fetch_stage #(.RESET_PC(WRAP_PC), .NOP_INSTR(NOP)) dut_w (
    .req(req), .reset(reset), .stall_in(stall_in), .redirect_in(redirect_in),
    .redirect_pc_in(redirect_pc_in), .imem_req_out(imem_req1),
    .imem_addr_out(imem_addr1), .imem_ack_in(ack1), .imem_rdata_in(rdata1),
    .instr_out(instr1), .pc_out(pc1), .valid_out(valid1)
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  // Architectural view of the stage: next PC to fetch, an optional parked
  // instruction (decode stalled), an optional stale request being waited
  // out, and what decode currently sees.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] flush_addr;
    logic [31:0] park_instr;
    logic [31:0] park_pc;
    logic [31:0] instr;
    logic [31:0] pc_o;
    logic        warmup;
    logic        parked;
    logic        flushing;
    logic        valid;
  } model_t;

  model_t m0, m1;

  function automatic model_t fresh(input logic [31:0] rpc);
    model_t n;
    n = '0;
    n.pc     = rpc;
    n.warmup = 1'b1;
    n.instr  = NOP;
    return n;
  endfunction

  function automatic logic m_req(input model_t m);
    return !m.warmup && !m.parked;
  endfunction

  function automatic logic [31:0] m_addr(input model_t m);
    return m.flushing ? m.flush_addr : m.pc;
  endfunction

  function automatic model_t step(input model_t m, input logic rst_n, input logic st,
                                  input logic rd, input logic [31:0] tg, input logic ak,
                                  input logic [31:0] rdata, input logic [31:0] rpc);
    model_t      n;
    logic [31:0] t;
    n = m;
    t = tg & 32'hFFFF_FFFC;
    if (!rst_n) return fresh(rpc);
    if (m.warmup) begin
      n.warmup = 1'b0;
    end else if (m.parked) begin
      if (rd) begin
        n.parked = 1'b0; n.pc = t; n.valid = 1'b0; n.instr = NOP;
      end else if (!st) begin
        n.parked = 1'b0; n.valid = 1'b1; n.instr = m.park_instr; n.pc_o = m.park_pc;
      end
    end else if (m.flushing) begin
      if (rd) n.pc = t;
      if (ak) n.flushing = 1'b0;
    end else begin
      if (rd) begin
        n.pc = t; n.valid = 1'b0; n.instr = NOP;
        if (!ak) begin n.flushing = 1'b1; n.flush_addr = m.pc; end
      end else if (ak) begin
        n.pc = m.pc + 32'd4;
        if (st) begin
          n.parked = 1'b1; n.park_instr = rdata; n.park_pc = m.pc;
        end else begin
          n.valid = 1'b1; n.instr = rdata; n.pc_o = m.pc;
        end
      end else if (!st) begin
        n.valid = 1'b0; n.instr = NOP;
      end
    end
    return n;
  endfunction

  // One clock: drive inputs at the falling edge, advance the models at the
  // rising edge, return at the next falling edge for sampling.
  task automatic cyc(input logic rst_n, input logic st, input logic rd,
                     input logic [31:0] tg, input logic ak0, input logic ak1);
    reset          = rst_n;
    stall_in       = st;
    redirect_in    = rd;
    redirect_pc_in = tg;
    ack0   = ak0 & m_req(m0);
    rdata0 = mem(m_addr(m0));
    ack1   = ak1 & m_req(m1);
    rdata1 = mem(m_addr(m1));
    @(posedge req);
    m0 = step(m0, rst_n, st, rd, tg, ack0, rdata0, 32'h0);
    m1 = step(m1, rst_n, st, rd, tg, ack1, rdata1, WRAP_PC);
    @(negedge req);
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_cmp++; if (imem_req0 !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b expected 0", imem_req0); end
    n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", valid0); end
    n_cmp++; if (instr0 !== NOP) begin n_bad++; $display("FAIL rst_instr: got %h expected %h", instr0, NOP); end
    n_cmp++; if (pc0 !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h expected 0", pc0); end
    n_cmp++; if (imem_req1 !== 1'b0) begin n_bad++; $display("FAIL rst_req_w: got %b expected 0", imem_req1); end
  endtask

  task automatic test_zero_wait();
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);  // idle cycle, nothing requested yet
    n_cmp++; if (imem_req0 !== 1'b1 || imem_addr0 !== 32'h0) begin n_bad++; $display("FAIL zw_first_req: got %b/%h expected 1/00000000", imem_req0, imem_addr0); end
    n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL zw_first_valid: got %b expected 0", valid0); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_cmp++; if (imem_addr0 !== 32'h4) begin n_bad++; $display("FAIL zw_addr4: got %h expected 00000004", imem_addr0); end
    n_cmp++; if (valid0 !== 1'b1 || pc0 !== 32'h0) begin n_bad++; $display("FAIL zw_out0: got %b/%h expected 1/00000000", valid0, pc0); end
    n_cmp++; if (instr0 !== mem(32'h0)) begin n_bad++; $display("FAIL zw_instr0: got %h expected %h", instr0, mem(32'h0)); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_cmp++; if (imem_addr0 !== 32'h8) begin n_bad++; $display("FAIL zw_addr8: got %h expected 00000008", imem_addr0); end
    n_cmp++; if (pc0 !== 32'h4 || instr0 !== mem(32'h4)) begin n_bad++; $display("FAIL zw_out4: got %h/%h expected 00000004/%h", pc0, instr0, mem(32'h4)); end
  endtask

  task automatic test_ack_delay();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      n_cmp++; if (imem_req0 !== 1'b1 || imem_addr0 !== 32'h8) begin n_bad++; $display("FAIL wait_addr[%0d]: got %b/%h expected 1/00000008", k, imem_req0, imem_addr0); end
      n_cmp++; if (valid0 !== 1'b0 || instr0 !== NOP) begin n_bad++; $display("FAIL wait_bubble[%0d]: got %b/%h expected 0/%h", k, valid0, instr0, NOP); end
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_cmp++; if (valid0 !== 1'b1 || pc0 !== 32'h8 || imem_addr0 !== 32'hC) begin n_bad++; $display("FAIL wait_done: got %b/%h/%h expected 1/00000008/0000000c", valid0, pc0, imem_addr0); end
  endtask

  task automatic test_stall_hold();
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);  // 0xC to decode, now at 0x10
    n_cmp++; if (imem_addr0 !== 32'h10) begin n_bad++; $display("FAIL hold_pre: got %h expected 00000010", imem_addr0); end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      n_cmp++; if (imem_req0 !== 1'b0) begin n_bad++; $display("FAIL hold_req[%0d]: got %b expected 0", k, imem_req0); end
      n_cmp++; if (valid0 !== 1'b1 || pc0 !== 32'hC || instr0 !== mem(32'hC)) begin n_bad++; $display("FAIL hold_frozen[%0d]: got %b/%h/%h expected 1/0000000c/%h", k, valid0, pc0, instr0, mem(32'hC)); end
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (valid0 !== 1'b1 || pc0 !== 32'h10 || instr0 !== mem(32'h10)) begin n_bad++; $display("FAIL hold_release: got %b/%h/%h expected 1/00000010/%h", valid0, pc0, instr0, mem(32'h10)); end
    n_cmp++; if (imem_req0 !== 1'b1 || imem_addr0 !== 32'h14) begin n_bad++; $display("FAIL hold_next_req: got %b/%h expected 1/00000014", imem_req0, imem_addr0); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_cmp++; if (pc0 !== 32'h14) begin n_bad++; $display("FAIL hold_once: got %h expected 00000014", pc0); end
  endtask

  task automatic test_redirect_pending();
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);  // 0x18
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);  // 0x1C, now at 0x20
    n_cmp++; if (imem_addr0 !== 32'h20) begin n_bad++; $display("FAIL rdp_pre: got %h expected 00000020", imem_addr0); end
    cyc(1'b1, 1'b0, 1'b1, 32'h103, 1'b0, 1'b0);
    n_cmp++; if (valid0 !== 1'b0 || instr0 !== NOP) begin n_bad++; $display("FAIL rdp_flush: got %b/%h expected 0/%h", valid0, instr0, NOP); end
    n_cmp++; if (imem_req0 !== 1'b1 || imem_addr0 !== 32'h20) begin n_bad++; $display("FAIL rdp_stale_req: got %b/%h expected 1/00000020", imem_req0, imem_addr0); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (imem_req0 !== 1'b1 || imem_addr0 !== 32'h20) begin n_bad++; $display("FAIL rdp_stale_hold: got %b/%h expected 1/00000020", imem_req0, imem_addr0); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);  // stale data accepted and dropped
    n_cmp++; if (valid0 !== 1'b0 || imem_addr0 !== 32'h100) begin n_bad++; $display("FAIL rdp_discard: got %b/%h expected 0/00000100", valid0, imem_addr0); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_cmp++; if (valid0 !== 1'b1 || pc0 !== 32'h100 || instr0 !== mem(32'h100)) begin n_bad++; $display("FAIL rdp_target: got %b/%h/%h expected 1/00000100/%h", valid0, pc0, instr0, mem(32'h100)); end
  endtask

  task automatic test_redirect_in_hold();
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);  // 0x104 parked
    n_cmp++; if (imem_req0 !== 1'b0 || pc0 !== 32'h100) begin n_bad++; $display("FAIL rih_hold: got %b/%h expected 0/00000100", imem_req0, pc0); end
    cyc(1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1);
    n_cmp++; if (valid0 !== 1'b0 || instr0 !== NOP) begin n_bad++; $display("FAIL rih_flush: got %b/%h expected 0/%h", valid0, instr0, NOP); end
    n_cmp++; if (imem_req0 !== 1'b1 || imem_addr0 !== 32'h200) begin n_bad++; $display("FAIL rih_restart: got %b/%h expected 1/00000200", imem_req0, imem_addr0); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_cmp++; if (valid0 !== 1'b1 || pc0 !== 32'h200) begin n_bad++; $display("FAIL rih_target: got %b/%h expected 1/00000200", valid0, pc0); end
  endtask

  task automatic test_wrap_reset();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (imem_req1 !== 1'b1 || imem_addr1 !== WRAP_PC) begin n_bad++; $display("FAIL wrap_wait: got %b/%h expected 1/%h", imem_req1, imem_addr1, WRAP_PC); end
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);  // reset mid-wait, ack ignored
    n_cmp++; if (imem_req1 !== 1'b0 || valid1 !== 1'b0) begin n_bad++; $display("FAIL wrap_abort: got %b/%b expected 0/0", imem_req1, valid1); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_cmp++; if (imem_req1 !== 1'b1 || imem_addr1 !== WRAP_PC) begin n_bad++; $display("FAIL wrap_a0: got %b/%h expected 1/%h", imem_req1, imem_addr1, WRAP_PC); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_cmp++; if (imem_addr1 !== 32'hFFFF_FFFC || pc1 !== WRAP_PC) begin n_bad++; $display("FAIL wrap_a1: got %h/%h expected fffffffc/%h", imem_addr1, pc1, WRAP_PC); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_cmp++; if (imem_addr1 !== 32'h0 || pc1 !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_a2: got %h/%h expected 00000000/fffffffc", imem_addr1, pc1); end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_cmp++; if (pc1 !== 32'h0 || instr1 !== mem(32'h0) || valid1 !== 1'b1) begin n_bad++; $display("FAIL wrap_out0: got %b/%h/%h expected 1/00000000/%h", valid1, pc1, instr1, mem(32'h0)); end
  endtask

  task automatic test_random();
    logic        rst_n, st, rd;
    logic [31:0] tg;
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(199) != 0);
      st    = ($urandom_range(9) < 3);
      rd    = ($urandom_range(19) == 0);
      tg    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      cyc(rst_n, st, rd, tg, $urandom_range(9) < 6, $urandom_range(9) < 6);
      n_cmp++; if (imem_req0 !== m_req(m0)) begin n_bad++; $display("FAIL rnd_req @%0d: got %b expected %b", i, imem_req0, m_req(m0)); end
      if (m_req(m0)) begin
        n_cmp++; if (imem_addr0 !== m_addr(m0)) begin n_bad++; $display("FAIL rnd_addr @%0d: got %h expected %h", i, imem_addr0, m_addr(m0)); end
      end
      n_cmp++; if (valid0 !== m0.valid) begin n_bad++; $display("FAIL rnd_valid @%0d: got %b expected %b", i, valid0, m0.valid); end
      n_cmp++; if (instr0 !== m0.instr) begin n_bad++; $display("FAIL rnd_instr @%0d: got %h expected %h", i, instr0, m0.instr); end
      if (m0.valid) begin
        n_cmp++; if (pc0 !== m0.pc_o) begin n_bad++; $display("FAIL rnd_pc @%0d: got %h expected %h", i, pc0, m0.pc_o); end
      end
      n_cmp++; if (imem_req1 !== m_req(m1)) begin n_bad++; $display("FAIL rnd_req_w @%0d: got %b expected %b", i, imem_req1, m_req(m1)); end
      if (m_req(m1)) begin
        n_cmp++; if (imem_addr1 !== m_addr(m1)) begin n_bad++; $display("FAIL rnd_addr_w @%0d: got %h expected %h", i, imem_addr1, m_addr(m1)); end
      end
      n_cmp++; if (valid1 !== m1.valid || instr1 !== m1.instr) begin n_bad++; $display("FAIL rnd_out_w @%0d: got %b/%h expected %b/%h", i, valid1, instr1, m1.valid, m1.instr); end
      if (m1.valid) begin
        n_cmp++; if (pc1 !== m1.pc_o) begin n_bad++; $display("FAIL rnd_pc_w @%0d: got %h expected %h", i, pc1, m1.pc_o); end
      end
    end
  endtask

  initial begin
    reset = 1'b0; stall_in = 1'b0; redirect_in = 1'b0; redirect_pc_in = 32'h0;
    ack0 = 1'b0; ack1 = 1'b0; rdata0 = 32'h0; rdata1 = 32'h0;
    m0 = fresh(32'h0);
    m1 = fresh(WRAP_PC);
    @(negedge req);
    test_reset();
    test_zero_wait();
    test_ack_delay();
    test_stall_hold();
    test_redirect_pending();
    test_redirect_in_hold();
    test_wrap_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
